song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Programmable multi-song note sequencer that drives the piano voice path with key_on/key/duration, like the fixed-tune player.
- Holds NUM_SONGS songs of up to MAX_LEN entries in internal RAM. Each entry carries its own note code and duration in ticks.
- Supports start/stop/pause, loop mode, and an articulation gap at the end of each note.
- Sits between the mode/control FSM (which loads songs and issues commands) and the tone generator.

Parameters:
- NOTE_W, 4, width of note code (key).
- DUR_W, 7, width of per-note duration in ticks; entry with dur=0 is the end-of-song marker.
- MAX_LEN, 32, entries per song (power of 2).
- NUM_SONGS, 4, number of song slots (power of 2).
- TICK_DIV, 1250000, clk cycles per duration tick (>=2).
- GAP_TICKS, 1, trailing silent ticks per note (0 = legato).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- wr_en, in, 1, program-write strobe, one entry per cycle.
- wr_song, in, log2(NUM_SONGS), song slot for write.
- wr_addr, in, log2(MAX_LEN), entry index for write.
- wr_note, in, NOTE_W, note code to store.
- wr_dur, in, DUR_W, duration to store (0 = end marker).
- start, in, 1, one-cycle pulse: play song song_sel from entry 0.
- song_sel, in, log2(NUM_SONGS), song selected, sampled with start.
- stop, in, 1, one-cycle pulse: abort playback.
- pause, in, 1, level: freeze playback while high.
- loop, in, 1, level: restart at entry 0 on reaching end of song.
- key_on, out, 1, note sounding.
- key, out, NOTE_W, current note code.
- duration, out, DUR_W, duration field of current entry.
- note_idx, out, log2(MAX_LEN), index of current entry.
- busy, out, 1, high in any state except IDLE.
- done, out, 1, one-cycle pulse on normal (non-looping) song completion.

Behaviour:
- Reset values: key_on=0, key=0, duration=0, note_idx=0, busy=0, done=0, state IDLE, tick counter 0. RAM contents are not reset. Reset mid-note silences the output immediately (asynchronous).
- RAM: NUM_SONGS*MAX_LEN entries of {note,dur}. Write is synchronous on wr_en. Read is combinational at {cur_song, idx}. A write to the song currently playing is legal and takes effect when that entry is next fetched.
- States: IDLE, FETCH, SOUND, GAP.
- IDLE:
  - start latches song_sel into cur_song, sets idx=0, moves to FETCH.
  - Otherwise holds; key and duration keep their last values.
- FETCH (exactly 1 cycle, key_on=0). Read entry E.
  - If E.dur=0:
    - If loop=1 and idx!=0: idx=0, stay in FETCH.
    - Else: done=1 for one cycle, go to IDLE. This includes an empty song, which must not spin forever.
  - Else: key<=E.note, duration<=E.dur, note_idx<=idx, key_on<=1. Compute S = (E.dur>GAP_TICKS) ? E.dur-GAP_TICKS : E.dur, and G = E.dur-S. Clear the tick counter and go to SOUND with rem=S.
- SOUND:
  - The tick counter counts 0..TICK_DIV-1; the tick fires on count TICK_DIV-1.
  - Each tick decrements rem. When rem reaches 0: key_on<=0.
    - If G>0: rem=G, go to GAP.
    - Else: increment idx and go to FETCH.
- GAP: key_on=0. Each tick decrements rem. At 0, increment idx and go to FETCH.
- Index wrap: when idx increments past MAX_LEN-1, treat it as an end marker. With loop=1, wrap to 0 and continue; with loop=0, pulse done and go to IDLE.
- Note period: dur*TICK_DIV+1 clocks (the +1 is FETCH). key_on is high for S*TICK_DIV clocks.
- pause=1:
  - Tick counter, rem and state are frozen, and key_on is forced to 0.
  - On release, playback resumes from the same count and key_on returns if state is SOUND.
  - pause in IDLE has no effect. start is still honoured while paused.
- stop: next cycle state=IDLE, key_on=0, busy=0, no done pulse.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - start while busy: restart immediately with the new song_sel (FETCH next cycle, key_on low that cycle).
  - wr_en concurrent with the FETCH of the same address: FETCH sees the old data.
- Width rules: rem is DUR_W bits. The tick counter is clog2(TICK_DIV) bits. dur never underflows because S>=1 whenever dur>=1.

Test Plan:
1. TICK_DIV=4, GAP_TICKS=1. Song 0 = {(5,3),(2,1),(x,0)}; start with song_sel=0 -> key_on high 1 cycle after FETCH.
   - Note 1: key=5, duration=3, key_on high 8 clocks then low 4, FETCH 1.
   - Note 2: key=2, duration=1, key_on high 4 clocks (S=dur since dur<=GAP), no GAP.
   - Then done=1 for exactly 1 cycle and busy falls.
2. Same song with loop=1 -> after entry 1, note_idx returns to 0 and key=5 repeats; done never pulses. Drop loop -> done after the current pass.
3. Song 1 programmed with all MAX_LEN=32 entries of dur=1, no marker -> indices 0..31 play in order.
   - loop=0: done after idx 31.
   - loop=1: idx wraps to 0.
4. Empty song (entry 0 dur=0) with loop=1 -> done pulses 1 cycle after FETCH, back to IDLE, no hang.
5. Assert pause for 10 clocks midway through SOUND of a dur=3 note -> key_on low during pause; total key_on-high time is still 8 clocks; the note ends 10 clocks later than unpaused.
6. stop mid-SOUND -> key_on=0 and busy=0 next cycle, no done. Assert start and stop together -> stays IDLE. Assert rst mid-note -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/song_sequencer.sv
// Multi-song note sequencer: plays {note,dur} entries from internal RAM into the
// piano voice path, with loop, pause, stop and a trailing articulation gap per note.
module song_sequencer #(
   parameter int NOTE_W    = 4,
   parameter int DUR_W     = 7,
   parameter int MAX_LEN   = 32,
   parameter int NUM_SONGS = 4,
   parameter int TICK_DIV  = 1250000,
   parameter int GAP_TICKS = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en_i,
   input  logic [$clog2(NUM_SONGS)-1:0] wr_song_i,
   input  logic [$clog2(MAX_LEN)-1:0]   wr_addr_i,
   input  logic [NOTE_W-1:0]            wr_note_i,
   input  logic [DUR_W-1:0]             wr_dur_i,
   input  logic                         start_i,
   input  logic [$clog2(NUM_SONGS)-1:0] song_sel_i,
   input  logic                         stop_i,
   input  logic                         pause_i,
   input  logic                         loop_i,
   output logic                         key_on_o,
   output logic [NOTE_W-1:0]            key_o,
   output logic [DUR_W-1:0]             duration_o,
   output logic [$clog2(MAX_LEN)-1:0]   note_idx_o,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int SW = $clog2(NUM_SONGS);
   localparam int AW = $clog2(MAX_LEN);
   localparam int TW = $clog2(TICK_DIV);
   localparam int EW = NOTE_W + DUR_W;
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] GAP_D     = DUR_W'(GAP_TICKS);
   localparam logic [DUR_W-1:0] REM_ONE   = DUR_W'(1);
   localparam logic [AW-1:0]    LAST_IDX  = AW'(MAX_LEN - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SOUND, GAP} state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     cur_song_q, cur_song_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [DUR_W-1:0]  rem_q, rem_d;
   logic [DUR_W-1:0]  gap_q, gap_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [NOTE_W-1:0] key_q, key_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [AW-1:0]     nidx_q, nidx_d;
   logic              key_on_q, key_on_d;
   logic              done_q, done_d;

   // Program RAM: not reset, synchronous write, combinational read.
   logic [EW-1:0] mem_q [NUM_SONGS*MAX_LEN];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[{wr_song_i, wr_addr_i}] <= {wr_note_i, wr_dur_i};
   end

   logic [EW-1:0]     ent;
   logic [NOTE_W-1:0] ent_note;
   logic [DUR_W-1:0]  ent_dur;
   logic [DUR_W-1:0]  s_len;
   logic              tick_fire;
   logic              adv;

   assign ent       = mem_q[{cur_song_q, idx_q}];
   assign ent_note  = ent[EW-1:DUR_W];
   assign ent_dur   = ent[DUR_W-1:0];
   // Short notes (dur <= gap) sound for their full length with no gap.
   assign s_len     = (ent_dur > GAP_D) ? ent_dur - GAP_D : ent_dur;
   assign tick_fire = (tick_q == TICK_LAST);

   always_comb begin
      state_d    = state_q;
      cur_song_d = cur_song_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      gap_d      = gap_q;
      tick_d     = tick_q;
      key_d      = key_q;
      dur_d      = dur_q;
      nidx_d     = nidx_q;
      key_on_d   = key_on_q;
      done_d     = 1'b0;
      adv        = 1'b0;

      if (stop_i) begin
         state_d  = IDLE;
         key_on_d = 1'b0;
      end else if (start_i) begin
         cur_song_d = song_sel_i;
         idx_d      = '0;
         key_on_d   = 1'b0;
         state_d    = FETCH;
      end else if (!pause_i) begin
         unique case (state_q)
            IDLE: ;
            FETCH: begin
               if (ent_dur == '0) begin
                  // idx!=0 guard keeps an empty looping song from spinning.
                  if (loop_i && idx_q != '0) begin
                     idx_d = '0;
                  end else begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  key_d    = ent_note;
                  dur_d    = ent_dur;
                  nidx_d   = idx_q;
                  key_on_d = 1'b1;
                  rem_d    = s_len;
                  gap_d    = ent_dur - s_len;
                  tick_d   = '0;
                  state_d  = SOUND;
               end
            end
            SOUND: begin
               tick_d = tick_fire ? '0 : tick_q + 1'b1;
               if (tick_fire) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == REM_ONE) begin
                     key_on_d = 1'b0;
                     if (gap_q != '0) begin
                        rem_d   = gap_q;
                        state_d = GAP;
                     end else begin
                        adv = 1'b1;
                     end
                  end
               end
            end
            GAP: begin
               tick_d = tick_fire ? '0 : tick_q + 1'b1;
               if (tick_fire) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == REM_ONE) adv = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Running past the last slot behaves as an end marker.
      if (adv) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (loop_i) begin
               state_d = FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_song_q <= '0;
         idx_q      <= '0;
         rem_q      <= '0;
         gap_q      <= '0;
         tick_q     <= '0;
         key_q      <= '0;
         dur_q      <= '0;
         nidx_q     <= '0;
         key_on_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_song_q <= cur_song_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         gap_q      <= gap_d;
         tick_q     <= tick_d;
         key_q      <= key_d;
         dur_q      <= dur_d;
         nidx_q     <= nidx_d;
         key_on_q   <= key_on_d;
         done_q     <= done_d;
      end
   end

   // key_on_q is only ever set in SOUND, so pause gating is inert in IDLE.
   assign key_on_o   = key_on_q & ~pause_i;
   assign key_o      = key_q;
   assign duration_o = dur_q;
   assign note_idx_o = nidx_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, GAP_TICKS=1; expected
// run lengths and field values are hand-derived from the sequencing rules.
module tb_song_sequencer;

   localparam int NOTE_W = 4, DUR_W = 7, MAX_LEN = 32, NUM_SONGS = 4;
   localparam int SW = 2, AW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [SW-1:0]     wr_song;
   logic [AW-1:0]     wr_addr;
   logic [NOTE_W-1:0] wr_note;
   logic [DUR_W-1:0]  wr_dur;
   logic              start, stop, pause, loop;
   logic [SW-1:0]     song_sel;
   logic              key_on, busy, done;
   logic [NOTE_W-1:0] key;
   logic [DUR_W-1:0]  duration;
   logic [AW-1:0]     note_idx;

   int vec_cnt = 0;
   int err_cnt = 0;
   int done_cnt = 0;

   song_sequencer #(
      .NOTE_W(NOTE_W), .DUR_W(DUR_W), .MAX_LEN(MAX_LEN), .NUM_SONGS(NUM_SONGS),
      .TICK_DIV(4), .GAP_TICKS(1)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en_i(wr_en), .wr_song_i(wr_song), .wr_addr_i(wr_addr),
      .wr_note_i(wr_note), .wr_dur_i(wr_dur),
      .start_i(start), .song_sel_i(song_sel), .stop_i(stop),
      .pause_i(pause), .loop_i(loop),
      .key_on_o(key_on), .key_o(key), .duration_o(duration),
      .note_idx_o(note_idx), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic prog(input int s, input int a, input int n, input int d);
      wr_en = 1'b1; wr_song = SW'(s); wr_addr = AW'(a);
      wr_note = NOTE_W'(n); wr_dur = DUR_W'(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Called at a negedge; returns on the FETCH cycle.
   task automatic pulse_start(input int s);
      start = 1'b1; song_sel = SW'(s);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts consecutive cycles with key_on==lvl; returns on the first differing cycle.
   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (key_on === lvl && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      vec_cnt++; if (key_on !== 1'b0) begin err_cnt++; $display("FAIL reset_key_on got %0b exp 0", key_on); end
      vec_cnt++; if (key !== '0) begin err_cnt++; $display("FAIL reset_key got %0d exp 0", key); end
      vec_cnt++; if (duration !== '0) begin err_cnt++; $display("FAIL reset_duration got %0d exp 0", duration); end
      vec_cnt++; if (note_idx !== '0) begin err_cnt++; $display("FAIL reset_note_idx got %0d exp 0", note_idx); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0b exp 0", busy); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %0b exp 0", done); end
   endtask

   task automatic test_basic;
      int n;
      pulse_start(0);
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_fetch_busy got %0b exp 1", busy); end
      vec_cnt++; if (key_on !== 1'b0) begin err_cnt++; $display("FAIL basic_fetch_key_on got %0b exp 0", key_on); end
      @(negedge clk);
      vec_cnt++; if (key !== 4'd5) begin err_cnt++; $display("FAIL basic_n1_key got %0d exp 5", key); end
      vec_cnt++; if (duration !== 7'd3) begin err_cnt++; $display("FAIL basic_n1_dur got %0d exp 3", duration); end
      vec_cnt++; if (note_idx !== 5'd0) begin err_cnt++; $display("FAIL basic_n1_idx got %0d exp 0", note_idx); end
      run_len(1'b1, n);
      vec_cnt++; if (n != 8) begin err_cnt++; $display("FAIL basic_n1_high got %0d exp 8", n); end
      run_len(1'b0, n);
      vec_cnt++; if (n != 5) begin err_cnt++; $display("FAIL basic_n1_low got %0d exp 5", n); end
      vec_cnt++; if (key !== 4'd2) begin err_cnt++; $display("FAIL basic_n2_key got %0d exp 2", key); end
      vec_cnt++; if (duration !== 7'd1) begin err_cnt++; $display("FAIL basic_n2_dur got %0d exp 1", duration); end
      vec_cnt++; if (note_idx !== 5'd1) begin err_cnt++; $display("FAIL basic_n2_idx got %0d exp 1", note_idx); end
      run_len(1'b1, n);
      vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL basic_n2_high got %0d exp 4", n); end
      vec_cnt++; if (busy !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL basic_marker busy/done got %0b/%0b exp 1/0", busy, done); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL basic_done busy/done got %0b/%0b exp 0/1", busy, done); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL basic_done_width got %0b exp 0", done); end
   endtask

   task automatic test_loop;
      int n, d0;
      loop = 1'b1;
      pulse_start(0);
      d0 = done_cnt;
      @(negedge clk);
      run_len(1'b1, n);
      vec_cnt++; if (n != 8) begin err_cnt++; $display("FAIL loop_n1_high got %0d exp 8", n); end
      run_len(1'b0, n);
      run_len(1'b1, n);
      vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL loop_n2_high got %0d exp 4", n); end
      run_len(1'b0, n);
      vec_cnt++; if (n != 2) begin err_cnt++; $display("FAIL loop_restart_low got %0d exp 2", n); end
      vec_cnt++; if (key !== 4'd5) begin err_cnt++; $display("FAIL loop_key got %0d exp 5", key); end
      vec_cnt++; if (note_idx !== 5'd0) begin err_cnt++; $display("FAIL loop_idx got %0d exp 0", note_idx); end
      loop = 1'b0;
      run_len(1'b1, n);
      run_len(1'b0, n);
      run_len(1'b1, n);
      vec_cnt++; if (done_cnt - d0 != 0) begin err_cnt++; $display("FAIL loop_no_done got %0d exp 0", done_cnt - d0); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL loop_exit_done got %0b exp 1", done); end
      @(negedge clk);
   endtask

   task automatic test_full_song;
      int n, d0;
      for (int i = 0; i < MAX_LEN; i++) prog(1, i, i % 16, 1);
      loop = 1'b1;
      pulse_start(1);
      d0 = done_cnt;
      for (int i = 0; i < MAX_LEN; i++) begin
         @(negedge clk);
         vec_cnt++; if (note_idx !== AW'(i)) begin err_cnt++; $display("FAIL full_loop_idx got %0d exp %0d", note_idx, i); end
         run_len(1'b1, n);
         vec_cnt++; if (n != 4) begin err_cnt++; $display("FAIL full_loop_high idx %0d got %0d exp 4", i, n); end
      end
      @(negedge clk);
      vec_cnt++; if (key_on !== 1'b1 || note_idx !== 5'd0) begin err_cnt++; $display("FAIL full_wrap key_on/idx got %0b/%0d exp 1/0", key_on, note_idx); end
      vec_cnt++; if (done_cnt - d0 != 0) begin err_cnt++; $display("FAIL full_loop_no_done got %0d exp 0", done_cnt - d0); end
      loop = 1'b0;
      run_len(1'b1, n);
      for (int i = 1; i < MAX_LEN; i++) begin
         @(negedge clk);
         vec_cnt++; if (note_idx !== AW'(i)) begin err_cnt++; $display("FAIL full_once_idx got %0d exp %0d", note_idx, i); end
         run_len(1'b1, n);
      end
      vec_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL full_end busy/done got %0b/%0b exp 0/1", busy, done); end
      @(negedge clk);
   endtask

   task automatic test_empty_song;
      prog(2, 0, 7, 0);
      loop = 1'b1;
      pulse_start(2);
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL empty_fetch_busy got %0b exp 1", busy); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL empty_done busy/done got %0b/%0b exp 0/1", busy, done); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL empty_idle busy/done got %0b/%0b exp 0/0", busy, done); end
      loop = 1'b0;
   endtask

   task automatic test_pause;
      int kon, t;
      prog(3, 0, 9, 3);
      prog(3, 1, 0, 0);
      pulse_start(3);
      @(negedge clk);
      kon = 0;
      for (t = 0; t < 100; t++) begin
         if (t == 3) pause = 1'b1;
         if (t == 13) pause = 1'b0;
         #1;
         if (key_on === 1'b1) kon++;
         if (t == 5) begin
            vec_cnt++; if (key_on !== 1'b0) begin err_cnt++; $display("FAIL pause_key_on got %0b exp 0", key_on); end
         end
         if (done === 1'b1) break;
         @(negedge clk);
      end
      vec_cnt++; if (kon != 8) begin err_cnt++; $display("FAIL pause_high_total got %0d exp 8", kon); end
      vec_cnt++; if (t != 23) begin err_cnt++; $display("FAIL pause_done_time got %0d exp 23", t); end
      @(negedge clk);
   endtask

   task automatic test_stop_restart;
      pulse_start(0);
      @(negedge clk);
      @(negedge clk);
      pulse_start(3);
      vec_cnt++; if (key_on !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL restart_fetch key_on/busy got %0b/%0b exp 0/1", key_on, busy); end
      @(negedge clk);
      vec_cnt++; if (key !== 4'd9 || key_on !== 1'b1) begin err_cnt++; $display("FAIL restart_key key/key_on got %0d/%0b exp 9/1", key, key_on); end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      vec_cnt++; if (key_on !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL stop key_on/busy/done got %0b/%0b/%0b exp 0/0/0", key_on, busy, done); end
      @(negedge clk);
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL stop_no_done got %0b exp 0", done); end
      start = 1'b1; stop = 1'b1; song_sel = 2'd0;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL start_stop_busy got %0b exp 0", busy); end
      @(negedge clk);
      vec_cnt++; if (busy !== 1'b0 || key_on !== 1'b0) begin err_cnt++; $display("FAIL start_stop_idle busy/key_on got %0b/%0b exp 0/0", busy, key_on); end
   endtask

   task automatic test_async_reset;
      pulse_start(0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vec_cnt++; if (key_on !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL arst key_on/busy/done got %0b/%0b/%0b exp 0/0/0", key_on, busy, done); end
      vec_cnt++; if (key !== '0 || duration !== '0 || note_idx !== '0) begin err_cnt++; $display("FAIL arst key/dur/idx got %0d/%0d/%0d exp 0/0/0", key, duration, note_idx); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_song = '0; wr_addr = '0; wr_note = '0; wr_dur = '0;
      start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; song_sel = '0;
      #12;
      test_reset;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      prog(0, 0, 5, 3);
      prog(0, 1, 2, 1);
      prog(0, 2, 0, 0);
      test_basic;
      test_loop;
      test_full_song;
      test_empty_song;
      test_pause;
      test_stop_restart;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
